// File: rtl/output_stream_tx_pkg.sv
// Shared constants and helpers for the output stream transmitter.
// Holds the default byte width, frame geometry and FIFO depth, plus a
// constant-evaluable ceil(log2) used to size pointers and counters.
package output_stream_tx_pkg;

    localparam int DATA_W    = 8;
    localparam int WIDTH     = 24;
    localparam int HEIGHT    = 24;
    localparam int FRAME_PIX = WIDTH * HEIGHT;
    localparam int DEPTH     = 32;

    // Number of bits needed to index 'value' distinct items (at least 1).
    function automatic int clog2(input int unsigned value);
        int r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = int'(i) + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/output_stream_tx_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_push, i_data write request and data (ignored while full)
//   i_pop          read request (ignored while empty)
//   o_data         head entry, valid whenever o_empty is 0
//   o_count        number of stored entries (0 .. DEPTH)
//   o_full/o_empty occupancy flags
module sync_fifo #(
    parameter int DATA_W = output_stream_tx_pkg::DATA_W,
    parameter int DEPTH  = output_stream_tx_pkg::DEPTH
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_push,
    input  logic [DATA_W-1:0]                          i_data,
    input  logic                                       i_pop,
    output logic [DATA_W-1:0]                          o_data,
    output logic [output_stream_tx_pkg::clog2(DEPTH):0] o_count,
    output logic                                       o_full,
    output logic                                       o_empty
);
    import output_stream_tx_pkg::*;

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

    always_comb begin
        push     = i_push && !o_full;
        pop      = i_pop && !o_empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/output_stream_tx.sv
// output_stream_tx: AXI-Stream master at the back of the inference datapath.
// Buffers result bytes in a FIFO, streams them out, flags the last beat of
// each WIDTH x HEIGHT frame and pulses an interrupt once per completed frame.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_data, i_valid, o_ready  push port from the compute stage
//   m_axis_*                  AXI-Stream master (data, valid, ready, last)
//   o_intr                    one-cycle pulse after a frame's last beat
//   o_ovf                     sticky: a byte arrived while the FIFO was full
//   o_frame_cnt               completed frames, modulo 256
module output_stream_tx #(
    parameter int DATA_W = output_stream_tx_pkg::DATA_W,
    parameter int WIDTH  = output_stream_tx_pkg::WIDTH,
    parameter int HEIGHT = output_stream_tx_pkg::HEIGHT,
    parameter int DEPTH  = output_stream_tx_pkg::DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] m_axis_data,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic              m_axis_last,
    output logic              o_intr,
    output logic              o_ovf,
    output logic [7:0]        o_frame_cnt
);
    import output_stream_tx_pkg::*;

    localparam int BEATS  = WIDTH * HEIGHT;
    localparam int BEAT_W = clog2(BEATS);
    localparam int CNT_W  = clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  count;
    logic              full, empty;
    logic              pop, last_beat;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              intr_q, intr_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        frame_q, frame_d;

    // The FIFO gates its own push with full and pop with empty.
    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_valid),
        .i_data  (i_data),
        .i_pop   (m_axis_ready),
        .o_data  (m_axis_data),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    assign o_ready      = (count < CNT_W'(DEPTH));
    assign m_axis_valid = !empty;
    assign last_beat    = (beat_q == BEAT_W'(BEATS - 1));
    assign m_axis_last  = m_axis_valid && last_beat;
    assign pop          = m_axis_valid && m_axis_ready;

    assign o_intr      = intr_q;
    assign o_ovf       = ovf_q;
    assign o_frame_cnt = frame_q;

    always_comb begin
        beat_d  = beat_q;
        if (pop) begin
            beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
        end
        intr_d  = pop && last_beat;
        frame_d = frame_q + 8'(intr_d);
        ovf_d   = ovf_q || (i_valid && full);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beat_q  <= '0;
            intr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            beat_q  <= beat_d;
            intr_q  <= intr_d;
            ovf_q   <= ovf_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: tb/tb_output_stream_tx.sv
// Testbench for output_stream_tx: queue-based reference model, randomized data.
module tb_output_stream_tx;

    localparam int DATA_W = 8;
    localparam int WIDTH  = 24;
    localparam int HEIGHT = 24;
    localparam int DEPTH  = 32;
    localparam int FRAME  = WIDTH * HEIGHT;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready = 1'b0;
    logic        m_axis_last;
    logic        o_intr;
    logic        o_ovf;
    logic [7:0]  o_frame_cnt;

    always #5 clk = ~clk;

    output_stream_tx #(
        .DATA_W (DATA_W),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .o_intr       (o_intr),
        .o_ovf        (o_ovf),
        .o_frame_cnt  (o_frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO is a plain queue; beat position is total pops mod FRAME.
    logic [7:0] mq[$];
    int         pcnt = 0;
    logic [7:0] fcnt = '0;
    logic       exp_intr = 1'b0;
    logic       exp_ovf = 1'b0;

    // Pre-edge samples of the DUT and of the model for the last tick.
    logic       ob_v, ob_l, ob_r;
    logic [7:0] ob_d;
    logic       ex_v, ex_l, ex_r;
    logic [7:0] ex_d;

    // One clock cycle: drive inputs at the falling edge, sample, advance the model at
    // the rising edge, and return at the next falling edge.
    task automatic tick(input logic rst_in, input logic v, input logic [7:0] d, input logic rdy);
        bit popped;
        i_rst = rst_in; i_valid = v; i_data = d; m_axis_ready = rdy;
        #1;
        ob_v = m_axis_valid; ob_d = m_axis_valid ? m_axis_data : 8'h00;
        ob_l = m_axis_last;  ob_r = o_ready;
        ex_v = (mq.size() != 0);
        ex_d = ex_v ? mq[0] : 8'h00;
        ex_l = ex_v && ((pcnt % FRAME) == FRAME - 1);
        ex_r = (mq.size() < DEPTH);
        @(posedge clk);
        if (rst_in) begin
            mq.delete(); pcnt = 0; fcnt = '0; exp_intr = 1'b0; exp_ovf = 1'b0;
        end else begin
            popped   = ex_v && rdy;
            exp_intr = popped && ex_l;
            if (popped) begin
                void'(mq.pop_front());
                pcnt++;
                if (ex_l) fcnt++;
            end
            if (v) begin
                if (ex_r) mq.push_back(d);
                else exp_ovf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", m_axis_valid); end
        checks++; if (m_axis_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", m_axis_last); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        checks++; if ({o_intr, o_frame_cnt, o_ovf} !== 10'h0) begin
            errors++; $display("FAIL reset_status got intr=%b frames=%0d ovf=%b exp 0/0/0", o_intr, o_frame_cnt, o_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        tick(1'b0, 1'b1, 8'hA5, 1'b1);
        checks++; if (ob_r !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", ob_r); end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if ({ob_v, ob_d, ob_l} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++; $display("FAIL single_beat got v=%b d=%h l=%b exp v=1 d=a5 l=0", ob_v, ob_d, ob_l);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (ob_v !== 1'b0) begin errors++; $display("FAIL single_drained got v=%b exp 0", ob_v); end
        checks++; if ({ob_v, ob_d, ob_l, ob_r} !== {ex_v, ex_d, ex_l, ex_r}) begin
            errors++; $display("FAIL single_model got %b/%h/%b/%b exp %b/%h/%b/%b", ob_v, ob_d, ob_l, ob_r, ex_v, ex_d, ex_l, ex_r);
        end
    endtask

    task automatic test_full_frame();
        int beat = 0, nlast = 0, last_at = -1, nintr = 0;
        do_reset();
        for (int i = 0; i < FRAME + 4; i++) begin
            tick(1'b0, i < FRAME, 8'(i), 1'b1);
            checks++; if ({ob_v, ob_d, ob_l, ob_r} !== {ex_v, ex_d, ex_l, ex_r}) begin
                errors++; $display("FAIL frame_stream i=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", i, ob_v, ob_d, ob_l, ob_r, ex_v, ex_d, ex_l, ex_r);
            end
            checks++; if ({o_intr, o_frame_cnt, o_ovf} !== {exp_intr, fcnt, exp_ovf}) begin
                errors++; $display("FAIL frame_status i=%0d got %b/%0d/%b exp %b/%0d/%b", i, o_intr, o_frame_cnt, o_ovf, exp_intr, fcnt, exp_ovf);
            end
            if (ob_v) begin
                checks++; if (ob_d !== 8'(beat)) begin errors++; $display("FAIL frame_order beat=%0d got %h exp %h", beat, ob_d, 8'(beat)); end
                if (ob_l) begin nlast++; last_at = beat; end
                beat++;
            end
            if (o_intr) nintr++;
        end
        checks++; if (beat !== FRAME) begin errors++; $display("FAIL frame_beats got %0d exp %0d", beat, FRAME); end
        checks++; if (nlast !== 1 || last_at !== FRAME - 1) begin
            errors++; $display("FAIL frame_last got count=%0d at=%0d exp 1 at %0d", nlast, last_at, FRAME - 1);
        end
        checks++; if (nintr !== 1) begin errors++; $display("FAIL frame_intr got %0d pulses exp 1", nintr); end
        checks++; if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL frame_cnt got %0d exp 1", o_frame_cnt); end
    endtask

    task automatic test_overflow();
        logic [7:0] sent[$];
        logic [7:0] d;
        int n = 0;
        bool_first: begin end
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            d = 8'($urandom);
            if (i < DEPTH) sent.push_back(d);
            tick(1'b0, 1'b1, d, 1'b0);
            checks++; if ({ob_v, ob_d, ob_l, ob_r} !== {ex_v, ex_d, ex_l, ex_r}) begin
                errors++; $display("FAIL ovf_fill i=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", i, ob_v, ob_d, ob_l, ob_r, ex_v, ex_d, ex_l, ex_r);
            end
        end
        checks++; if (ob_r !== 1'b0) begin errors++; $display("FAIL ovf_full_ready got %b exp 0", ob_r); end
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", o_ovf); end
        for (int c = 0; c < DEPTH + 8; c++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1);
            if (c == 1) begin
                checks++; if (ob_r !== 1'b1) begin errors++; $display("FAIL ovf_ready_back got %b exp 1", ob_r); end
            end
            if (ob_v) begin
                checks++; if (n >= DEPTH || ob_d !== sent[n]) begin
                    errors++; $display("FAIL ovf_drain n=%0d got %h exp %h", n, ob_d, (n < DEPTH) ? sent[n] : 8'hxx);
                end
                n++;
            end
        end
        checks++; if (n !== DEPTH) begin errors++; $display("FAIL ovf_count got %0d beats exp %0d", n, DEPTH); end
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", o_ovf); end
    endtask

    task automatic test_backpressure();
        logic [7:0] src[$];
        int si = 0, ro = 0;
        logic v, rdy, pv, pr, pl;
        logic [7:0] pd, d;
        do_reset();
        for (int i = 0; i < FRAME; i++) src.push_back(8'($urandom));
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        for (int c = 0; c < 8000 && ro < FRAME; c++) begin
            v   = (si < FRAME) && (mq.size() < DEPTH) && ($urandom_range(3) != 0);
            d   = v ? src[si] : 8'($urandom);
            rdy = $urandom_range(1) == 1;
            if (v) si++;
            tick(1'b0, v, d, rdy);
            checks++; if ({ob_v, ob_d, ob_l, ob_r} !== {ex_v, ex_d, ex_l, ex_r}) begin
                errors++; $display("FAIL bp_stream c=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", c, ob_v, ob_d, ob_l, ob_r, ex_v, ex_d, ex_l, ex_r);
            end
            if (pv && !pr) begin
                checks++; if ({ob_v, ob_d, ob_l} !== {1'b1, pd, pl}) begin
                    errors++; $display("FAIL bp_stable c=%0d got %b/%h/%b exp 1/%h/%b", c, ob_v, ob_d, ob_l, pd, pl);
                end
            end
            if (ob_v && rdy) begin
                checks++; if (ob_d !== src[ro]) begin errors++; $display("FAIL bp_order beat=%0d got %h exp %h", ro, ob_d, src[ro]); end
                ro++;
            end
            pv = ob_v; pr = rdy; pd = ob_d; pl = ob_l;
        end
        checks++; if (ro !== FRAME) begin errors++; $display("FAIL bp_timeout got %0d beats exp %0d", ro, FRAME); end
        checks++; if ({o_frame_cnt, o_ovf} !== {8'd1, 1'b0}) begin
            errors++; $display("FAIL bp_status got frames=%0d ovf=%b exp 1/0", o_frame_cnt, o_ovf);
        end
    endtask

    task automatic test_simul();
        logic [7:0] order[$];
        logic [7:0] d;
        do_reset();
        d = 8'($urandom);
        order.push_back(d);
        tick(1'b0, 1'b1, d, 1'b0);
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            order.push_back(d);
            tick(1'b0, 1'b1, d, 1'b1);
            checks++; if ({ob_v, ob_r, ob_d} !== {1'b1, 1'b1, order[i]}) begin
                errors++; $display("FAIL simul i=%0d got v=%b r=%b d=%h exp 1/1/%h", i, ob_v, ob_r, ob_d, order[i]);
            end
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if ({ob_v, ob_d} !== {1'b1, order[20]}) begin
            errors++; $display("FAIL simul_tail got v=%b d=%h exp 1/%h", ob_v, ob_d, order[20]);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (ob_v !== 1'b0) begin errors++; $display("FAIL simul_empty got v=%b exp 0", ob_v); end
    endtask

    task automatic test_reset_mid();
        int beat = 0, nlast = 0, last_at = -1;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i <= 300; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b1);
        checks++; if (pcnt !== 300 || ob_v !== 1'b1) begin
            errors++; $display("FAIL mid_pre got pops=%0d v=%b exp 300/1", pcnt, ob_v);
        end
        do_reset();
        #1;
        checks++; if ({m_axis_valid, o_frame_cnt} !== {1'b0, 8'd0}) begin
            errors++; $display("FAIL mid_after_reset got v=%b frames=%0d exp 0/0", m_axis_valid, o_frame_cnt);
        end
        @(negedge clk);
        for (int i = 0; i < FRAME + 4; i++) begin
            d = 8'($urandom);
            tick(1'b0, i < FRAME, d, 1'b1);
            checks++; if ({ob_v, ob_d, ob_l, ob_r} !== {ex_v, ex_d, ex_l, ex_r}) begin
                errors++; $display("FAIL mid_stream i=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", i, ob_v, ob_d, ob_l, ob_r, ex_v, ex_d, ex_l, ex_r);
            end
            if (ob_v) begin
                if (ob_l) begin nlast++; last_at = beat; end
                beat++;
            end
        end
        checks++; if (nlast !== 1 || last_at !== FRAME - 1) begin
            errors++; $display("FAIL mid_last got count=%0d at=%0d exp 1 at %0d", nlast, last_at, FRAME - 1);
        end
        checks++; if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL mid_frames got %0d exp 1", o_frame_cnt); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_full_frame();
        test_overflow();
        test_backpressure();
        test_simul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_stream_tx.md
Name: output_stream_tx

Overview:
- AXI-Stream master transmitter at the back end of the inference datapath; the counterpart of the input line-buffer receiver.
- Accepts result bytes from the compute stage through a valid/ready push port and buffers them in a small synchronous FIFO.
- Streams the bytes out on an AXI-Stream master port, marks the last beat of each WIDTH×HEIGHT feature map, and pulses an interrupt when a frame completes.

Parameters:
- DATA_W, 8, byte width of the result and stream data.
- WIDTH, 24, output feature-map columns.
- HEIGHT, 24, output feature-map rows.
- DEPTH, 32, FIFO entries; must be a power of 2, minimum 2.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_data  in  DATA_W  result byte from the compute stage.
- i_valid  in  1  i_data is valid this cycle.
- o_ready  out  1  FIFO can accept a byte this cycle.
- m_axis_data  out  DATA_W  stream data.
- m_axis_valid  out  1  stream data is valid.
- m_axis_ready  in  1  downstream accepts the beat.
- m_axis_last  out  1  last beat of the frame.
- o_intr  out  1  one-cycle pulse when a frame completes.
- o_ovf  out  1  sticky flag: a byte was dropped.
- o_frame_cnt  out  8  number of completed frames, modulo 256.

Behaviour:
- Reset (i_rst high at a clock edge):
  - FIFO count, read pointer, write pointer, beat counter, o_frame_cnt, o_intr and o_ovf all clear to 0.
  - FIFO contents are discarded.
  - In the cycle after the reset edge: m_axis_valid=0, m_axis_last=0, o_ready=1 (once i_rst is low).
  - Reset mid-frame abandons the frame. The next beat sent is beat 0 of a new frame.
- Push:
  - A push happens when i_valid and o_ready are both 1.
  - o_ready = (count < DEPTH). It is derived from the registered count, so it does not depend on the current-cycle pop.
  - When full, no push happens, even if a pop occurs in the same cycle.
- Drop:
  - i_valid=1 with o_ready=0: the byte is discarded and o_ovf is set.
  - o_ovf stays 1 until reset.
- Pop:
  - A pop happens when m_axis_valid and m_axis_ready are both 1.
  - m_axis_valid = (count != 0).
  - m_axis_data = mem[rd_ptr], first-word fall-through.
- Latency: a byte pushed at edge N is visible on m_axis_data/valid in the cycle after edge N (1 cycle when the FIFO was empty).
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any count between 1 and DEPTH-1.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- AXI stability: while m_axis_valid=1 and m_axis_ready=0, m_axis_data and m_axis_last stay constant. This follows from the head changing only on a pop.
- Beat counter:
  - Counts 0 .. WIDTH*HEIGHT-1 and increments on each pop.
  - Wraps to 0 on the pop where it equals WIDTH*HEIGHT-1.
  - Width is clog2(WIDTH*HEIGHT).
- m_axis_last = m_axis_valid && (beat counter == WIDTH*HEIGHT-1).
- Frame completion, on a pop with m_axis_last=1:
  - o_intr is 1 in the following cycle only.
  - o_frame_cnt increments; it wraps from 255 to 0.
- Back-to-back frames: o_intr pulses once per frame, even if the last beat of one frame is followed immediately by beat 0 of the next.
- m_axis_ready is ignored while m_axis_valid=0.

Decomposition:
- Shared package holds:
  - DATA_W;
  - frame constants FRAME_PIX = WIDTH*HEIGHT;
  - a clog2 function for the counter and pointer widths.
- One sub-module, sync_fifo:
  - Parameters DATA_W and DEPTH.
  - Push/pop ports, count, full/empty.
  - Synchronous active-high reset on i_clk.
- Beat counter, frame logic, drop detection and interrupt stay in output_stream_tx.

Test Plan:
- Single byte: push 0xA5 with m_axis_ready=1.
  - Required: m_axis_valid=1 and data=0xA5 one cycle later; popped the same cycle; m_axis_last=0; count returns to 0.
- Full frame: push 576 bytes (values i mod 256), one per cycle, with m_axis_ready held at 1.
  - Required: all 576 beats arrive in order; m_axis_last is 1 only on beat 575; o_intr pulses once, one cycle after beat 575; o_frame_cnt=1.
- Fill and overflow: hold m_axis_ready=0 and push 33 bytes.
  - Required: after 32 pushes, o_ready=0; the 33rd byte is dropped and o_ovf=1.
  - Then set m_axis_ready=1. Required: exactly 32 beats drain, o_ovf stays 1, and o_ready returns to 1 after the first pop.
- Backpressure stability: toggle m_axis_ready randomly (about 50%) over a full frame.
  - Required: data and last never change while valid=1 and ready=0; the output sequence is identical to the input sequence.
- Simultaneous push/pop: with count=1, push each cycle and pop each cycle for 20 cycles.
  - Required: count stays 1, o_ready stays 1, and the order is preserved.
- Reset mid-frame: after 300 beats, assert i_rst for 1 cycle, then send a new frame of 576 bytes.
  - Required: m_axis_valid=0 the cycle after reset; o_frame_cnt=0; m_axis_last appears on new beat 575 and not earlier.
